ame_equation_builder: RTL
=========================

Name: ame_equation_builder

Overview:
- Streaming accumulator directly upstream of the affine ME equation solver.
- Consumes one gradient-coefficient vector and one residual per pixel, and accumulates the normal equations A += c·cᵀ and B += c·d.
- Presents the 6 x 7 integer augmented matrix in the solver's input layout, then pulses done so the controller can launch the solver.
- Supports 4-parameter and 6-parameter affine modes.

Parameters:
- COMP_DATA_BITS, 64: accumulator and output element width, two's complement.
- COEF_BITS, 16: signed width of each coefficient and of the residual.
- COMP_CNT_BITS, 16: width of the accepted-sample counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- comp_init_i  in  1  start of a new block; clears accumulators.
- comp_done_o  out  1  one-cycle pulse; comp_data_o valid.
- affine_param6_i  in  1  1 = 6-param, 0 = 4-param; sampled at comp_init_i.
- in_valid_i  in  1  sample valid.
- in_ready_o  out  1  sample accepted when in_valid_i & in_ready_o.
- in_last_i  in  1  marks the final sample of the block.
- in_coef_i  in  6 x COEF_BITS  signed c0..c5.
- in_diff_i  in  COEF_BITS  signed residual d.
- comp_data_o  out  6 x 7 x COMP_DATA_BITS  [i][j<6] = Aij, [i][6] = Bi.
- comp_count_o  out  COMP_CNT_BITS  number of accepted samples.

Behaviour:
- Reset: comp_done_o=0, in_ready_o=0, comp_data_o=0, comp_count_o=0, all accumulators and pipeline valids 0, state IDLE.
- IDLE:
  - in_ready_o=0.
  - comp_init_i=1: clear 27 accumulators and counter; latch param6 mode; go to ACCUM.
  - comp_data_o keeps its previous contents.
- ACCUM:
  - in_ready_o=1. comp_init_i is ignored.
  - Each accepted sample increments the counter (wraps modulo 2^COMP_CNT_BITS).
  - Accepted sample with in_last_i=1: go to DRAIN; in_ready_o drops the next cycle.
- DRAIN: in_ready_o=0. Stay until both pipeline stage valids are 0, then go to DONE.
- DONE:
  - Register mirrored matrix into comp_data_o and counter into comp_count_o.
  - Pulse comp_done_o for exactly 1 cycle; return to IDLE.
- Pipeline:
  - S1 registers 21 upper-triangle products ci·cj (i<=j) and 6 products ci·d, each 2·COEF_BITS signed.
  - S2 sign-extends each product to COMP_DATA_BITS and adds it to its accumulator.
- Latency: last sample accepted at edge E0 -> S1 at E1 -> accumulate at E2 -> comp_data_o registered at E3. comp_done_o is high during the cycle after E3, i.e. 3 cycles after last acceptance.
- Back-to-back samples are accepted every cycle with no bubbles.
- Mirroring: output Aji = Aij for j<i. Only 21 A accumulators exist.
- 4-param mode:
  - c0, c1 are forced to 0 before multiply.
  - Rows 0-1 and columns 0-1 of comp_data_o are 0.
  - The meaningful data is rows 2..5, columns 2..6.
- Overflow: accumulators wrap modulo 2^COMP_DATA_BITS; no saturation. With defaults, overflow needs more than 2^32 samples, so it cannot occur in normal use.
- in_valid_i while in_ready_o=0: ignored; no state change.
- in_last_i with in_valid_i=0: ignored.
- comp_init_i during DRAIN or DONE: ignored; the sender must wait for comp_done_o.
- comp_init_i in the same cycle comp_done_o is high: accepted, because the FSM is already in IDLE.
- Reset mid-block: everything returns to reset values immediately; no comp_done_o is produced.

Test Plan:
- 6-param, one sample c=(1,2,3,4,5,6), d=7, last=1 -> done 3 cycles after acceptance. A00=1, A05=A50=6, A55=36, A23=A32=12, B0=7, B5=42, count=1.
- 4-param, same sample -> rows/cols 0-1 all 0. A22=9, A25=18, A55=36, B2=21, B5=42.
- 6-param, 4 back-to-back samples, each c=(-1,0,0,0,0,2), d=-3, valid held high -> ready stays 1 throughout, no bubbles. A00=4, A05=A50=-8, A55=16, B0=12, B5=-24, count=4.
- Valid gaps: 3 samples separated by idle cycles, last on the 3rd -> results equal the gapless run; one done pulse only.
- Two consecutive blocks, second init asserted in the done cycle -> second block's results exclude first block's data; comp_data_o holds block 1 values until block 2's done.
- Reset asserted 1 cycle after the 2nd of 5 samples -> comp_done_o never pulses, outputs all 0. After reset, a fresh single-sample block is correct.

Source files
------------

// File: rtl/ame_equation_builder.sv
// Accumulates the 6x7 affine ME normal-equation matrix from per-pixel coefficient/residual samples.
// Latency: comp_done_o 3 cycles after last accept; in_ready_o low outside ACCUM, no bubbles within a block.
module ame_equation_builder #(
    parameter int COMP_DATA_BITS = 64,
    parameter int COEF_BITS      = 16,
    parameter int COMP_CNT_BITS  = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic                                         comp_init_i,
    output logic                                         comp_done_o,
    input  logic                                         affine_param6_i,
    input  logic                                         in_valid_i,
    output logic                                         in_ready_o,
    input  logic                                         in_last_i,
    input  logic [5:0][COEF_BITS-1:0]                    in_coef_i,
    input  logic [COEF_BITS-1:0]                         in_diff_i,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]          comp_data_o,
    output logic [COMP_CNT_BITS-1:0]                     comp_count_o
);

    localparam int PW = 2 * COEF_BITS;
    localparam int NA = 21;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Packed position of the upper-triangle element (min(r,c), max(r,c)).
    function automatic int tri_idx(input int r, input int c);
        int lo;
        int hi;
        lo = (r < c) ? r : c;
        hi = (r < c) ? c : r;
        return lo * 6 - (lo * (lo - 1)) / 2 + (hi - lo);
    endfunction

    logic [1:0]                 state;
    logic                       param6;
    logic                       s1_vld;
    logic [COMP_CNT_BITS-1:0]   cnt;
    logic                       accept;

    logic signed [PW-1:0]       ce [6];
    logic signed [PW-1:0]       de;
    logic signed [PW-1:0]       prod_a_nxt [NA];
    logic signed [PW-1:0]       prod_b_nxt [6];
    logic signed [PW-1:0]       prod_a [NA];
    logic signed [PW-1:0]       prod_b [6];

    logic signed [COMP_DATA_BITS-1:0] acc_a [NA];
    logic signed [COMP_DATA_BITS-1:0] acc_b [6];
    logic [5:0][6:0][COMP_DATA_BITS-1:0] data_nxt;

    assign in_ready_o = (state == ST_ACCUM);
    assign accept     = in_valid_i & in_ready_o;

    // 4-parameter mode zeroes c0/c1 so their rows and columns stay 0.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            if (k < 2 && !param6) begin
                ce[k] = '0;
            end else begin
                ce[k] = PW'($signed(in_coef_i[k]));
            end
        end
        de = PW'($signed(in_diff_i));
    end

    always_comb begin
        for (int k = 0; k < NA; k++) begin
            prod_a_nxt[k] = '0;
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = i; j < 6; j++) begin
                prod_a_nxt[tri_idx(i, j)] = ce[i] * ce[j];
            end
            prod_b_nxt[i] = ce[i] * de;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_vld <= 1'b0;
            for (int k = 0; k < NA; k++) begin
                prod_a[k] <= '0;
            end
            for (int k = 0; k < 6; k++) begin
                prod_b[k] <= '0;
            end
        end else begin
            s1_vld <= accept;
            if (accept) begin
                prod_a <= prod_a_nxt;
                prod_b <= prod_b_nxt;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NA; k++) begin
                acc_a[k] <= '0;
            end
            for (int k = 0; k < 6; k++) begin
                acc_b[k] <= '0;
            end
        end else if (state == ST_IDLE && comp_init_i) begin
            for (int k = 0; k < NA; k++) begin
                acc_a[k] <= '0;
            end
            for (int k = 0; k < 6; k++) begin
                acc_b[k] <= '0;
            end
        end else if (s1_vld) begin
            for (int k = 0; k < NA; k++) begin
                acc_a[k] <= acc_a[k] + COMP_DATA_BITS'(prod_a[k]);
            end
            for (int k = 0; k < 6; k++) begin
                acc_b[k] <= acc_b[k] + COMP_DATA_BITS'(prod_b[k]);
            end
        end
    end

    // Only the upper triangle is accumulated; the lower half is mirrored here.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                data_nxt[i][j] = acc_a[tri_idx(i, j)];
            end
            data_nxt[i][6] = acc_b[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            param6       <= 1'b0;
            cnt          <= '0;
            comp_done_o  <= 1'b0;
            comp_data_o  <= '0;
            comp_count_o <= '0;
        end else begin
            comp_done_o <= (state == ST_DONE);
            if (accept) begin
                cnt <= cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (comp_init_i) begin
                        cnt    <= '0;
                        param6 <= affine_param6_i;
                        state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept && in_last_i) begin
                        state <= ST_DRAIN;
                    end
                end
                // Accumulators absorb the product stage on the edge after it empties.
                ST_DRAIN: begin
                    if (!s1_vld) begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    comp_data_o  <= data_nxt;
                    comp_count_o <= cnt;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
